// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and width constants for the data cache
package dcache_pkg;
    localparam int BLOCK_W    = 128;
    localparam int WORD_W     = 32;
    localparam int MEM_ADDR_W = 28;
    localparam int OFFSET_W   = 4;
    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/dirty/tag/data line storage with combinational read and synchronous word-write or line-fill
// Ports: clock, reset (async, clears valid/dirty only), index_i selects the line for both read and write;
//        valid_o/dirty_o/tag_o/data_o read the selected line; word_we_i writes word_i into word word_sel_i and marks
//        the line dirty; fill_i loads fill_tag_i/fill_data_i, sets valid and clears dirty (fill has priority).
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int INDEX_W  = $clog2(NUM_SETS),
    parameter int TAG_W    = MEM_ADDR_W - INDEX_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INDEX_W-1:0] index_i,
    output logic               valid_o,
    output logic               dirty_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic [BLOCK_W-1:0] data_o,
    input  logic               word_we_i,
    input  logic [1:0]         word_sel_i,
    input  logic [WORD_W-1:0]  word_i,
    input  logic               fill_i,
    input  logic [TAG_W-1:0]   fill_tag_i,
    input  logic [BLOCK_W-1:0] fill_data_i
);
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [BLOCK_W-1:0]  data_q [NUM_SETS];

    assign valid_o = valid_q[index_i];
    assign dirty_o = dirty_q[index_i];
    assign tag_o   = tag_q[index_i];
    assign data_o  = data_q[index_i];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[index_i] <= 1'b1;
            dirty_q[index_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[index_i] <= 1'b1;
        end
    end

    // Tag and data need no reset: an invalid line is never read as a hit.
    always_ff @(posedge clock) begin
        if (fill_i) begin
            tag_q[index_i]  <= fill_tag_i;
            data_q[index_i] <= fill_data_i;
        end else if (word_we_i) begin
            data_q[index_i][WORD_W*word_sel_i +: WORD_W] <= word_i;
        end
    end
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate data cache between the CPU and 128-bit block memory
// Ports: clock, reset (async active-high); CPU side read/write/address/writedata in, readdata/busywait out;
//        memory side mem_read/mem_write/mem_address/mem_writedata out, mem_readdata/mem_busywait in.
//        With DCACHE_STATS_EN defined, saturating hit_count/miss_count outputs are added.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           address,
    input  logic [WORD_W-1:0]     writedata,
    output logic [WORD_W-1:0]     readdata,
    output logic                  busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]    mem_writedata,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);
    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = MEM_ADDR_W - INDEX_W;

    state_t state_q, state_d;
    logic [TAG_W-1:0]   addr_tag, line_tag;
    logic [INDEX_W-1:0] index;
    logic [1:0]         word;
    logic               line_valid, line_dirty, request, hit, idle;
    logic [BLOCK_W-1:0] line_data;
    logic               unused_addr_bits;

    assign addr_tag         = address[31 -: TAG_W];
    assign index            = address[OFFSET_W +: INDEX_W];
    assign word             = address[3:2];
    assign unused_addr_bits = ^address[1:0];
    assign request          = read | write;
    assign idle             = state_q == IDLE;
    assign hit              = line_valid && line_tag == addr_tag;

    dcache_line_array #(.NUM_SETS(NUM_SETS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_lines (
        .clock       (clock),
        .reset       (reset),
        .index_i     (index),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .tag_o       (line_tag),
        .data_o      (line_data),
        .word_we_i   (idle && hit && write),
        .word_sel_i  (word),
        .word_i      (writedata),
        .fill_i      (state_q == UPDATE),
        .fill_tag_i  (addr_tag),
        .fill_data_i (mem_readdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Memory-side outputs decode from the registered state only, so an async
    // reset drops them immediately; busywait is also forced low under reset.
    always_comb begin
        state_d       = state_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        busywait      = request && !reset && !(idle && hit);
        readdata      = (idle && hit) ? line_data[WORD_W*word +: WORD_W] : '0;
        unique case (state_q)
            IDLE:      if (request && !hit) state_d = line_dirty ? WRITEBACK : FETCH;
            WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {line_tag, index};
                mem_writedata = line_data;
                if (!mem_busywait) state_d = FETCH;
            end
            FETCH: begin
                mem_read    = 1'b1;
                mem_address = {addr_tag, index};
                if (!mem_busywait) state_d = UPDATE;
            end
            UPDATE:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic        refill_q;
    logic [31:0] hit_q, miss_q;
    // refill_q marks the re-lookup cycle after a fill, which is not a new request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            refill_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            refill_q <= state_q == UPDATE;
            if (idle && request && hit && !refill_q && hit_q != '1) hit_q <= hit_q + 32'd1;
            if (idle && request && !hit && miss_q != '1) miss_q <= miss_q + 32'd1;
        end
    end
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed scoreboard bench for dcache_controller with a 16-beat block memory model
module tb_dcache_controller;
    logic         clock = 1'b0;
    logic         reset, read, write;
    logic [31:0]  address, writedata, readdata;
    logic         busywait, mem_read, mem_write, mem_busywait;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata, mem_readdata;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;

    dcache_controller dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Block memory: each byte holds the low 8 bits of its own byte address;
    // read data is latched at the completing beat and held afterwards.
    int           beat;
    logic [127:0] rdata_q;

    function automatic logic [127:0] pattern(input logic [27:0] blk);
        logic [127:0] p;
        for (int i = 0; i < 16; i++) p[8*i +: 8] = {blk[3:0], 4'(i)};
        return p;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            beat    <= 0;
            rdata_q <= '0;
        end else if (mem_read | mem_write) begin
            if (beat == 15) begin
                beat <= 0;
                if (mem_read) rdata_q <= pattern(mem_address);
            end else begin
                beat <= beat + 1;
            end
        end
    end
    assign mem_busywait = (mem_read | mem_write) && beat != 15;
    assign mem_readdata = rdata_q;

    typedef struct {
        bit          wr;
        logic [27:0] addr;
        logic [31:0] w1;
    } txn_t;
    txn_t        txq[$];
    logic [31:0] rdq[$];
    int          ntxn = 0;
    logic [1:0]  prev_rw = 2'b00;

    // Each new memory transaction is matched against the next expected one.
    always @(negedge clock) begin
        txn_t t;
        check("rw_exclusive", mem_read & mem_write, 1'b0);
        if ({mem_read, mem_write} != 2'b00 && {mem_read, mem_write} != prev_rw) begin
            ntxn++;
            check("txn_expected", txq.size() != 0, 1'b1);
            if (txq.size() != 0) begin
                t = txq.pop_front();
                check("txn_kind", mem_write, t.wr);
                check("txn_addr", mem_address, t.addr);
                if (t.wr) check("wb_word1", mem_writedata[63:32], t.w1);
            end
        end
        prev_rw = {mem_read, mem_write};
    end

    task automatic expect_txn(input bit wr, input logic [27:0] a, input logic [31:0] w1);
        txn_t t;
        t.wr = wr;
        t.addr = a;
        t.w1 = w1;
        txq.push_back(t);
    endtask

    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input int exp_lat, input string tag);
        int cyc = 0;
        logic [31:0] exp;
        @(posedge clock); #1;
        read = !wr;
        write = wr;
        address = a;
        writedata = wd;
        if (!wr) rdq.push_back(exp_rd);
        @(negedge clock);
        while (busywait && cyc < 100) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
        end
        check({tag, "_latency"}, 128'(cyc), 128'(exp_lat));
        if (!wr) begin
            exp = rdq.pop_front();
            check({tag, "_readdata"}, readdata, exp);
        end
        @(posedge clock); #1;
        read = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        read = 1'b0;
        write = 1'b0;
        address = '0;
        writedata = '0;
        #12;
        check("rst_busywait", busywait, 1'b0);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_address", mem_address, 28'h0);
        check("rst_mem_writedata", mem_writedata, 128'h0);
        check("rst_readdata", readdata, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        expect_txn(1'b0, 28'h0000004, 32'h0);
        access(1'b0, 32'h0000_0040, 32'h0, 32'h4342_4140, 18, "clean_miss");
        access(1'b0, 32'h0000_004C, 32'h0, 32'h4F4E_4D4C, 0, "read_hit");

        n = ntxn;
        access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 32'h0, 0, "write_hit");
        check("write_hit_dirty", dut.u_lines.dirty_q[4], 1'b1);
        check("write_hit_no_traffic", 128'(ntxn), 128'(n));

        expect_txn(1'b1, 28'h0000004, 32'hDEAD_BEEF);
        expect_txn(1'b0, 28'h000000C, 32'h0);
        access(1'b0, 32'h0000_00C0, 32'h0, 32'hC3C2_C1C0, 34, "dirty_miss");
        check("dirty_miss_clean", dut.u_lines.dirty_q[4], 1'b0);

        expect_txn(1'b0, 28'h0000010, 32'h0);
        access(1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0, 18, "write_miss");
        check("write_miss_dirty", dut.u_lines.dirty_q[0], 1'b1);
`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, 32'd2);
        check("miss_count", miss_count, 32'd3);
`endif
        access(1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 0, "alloc_word0");
        access(1'b0, 32'h0000_0104, 32'h0, 32'h0706_0504, 0, "alloc_word1");

        expect_txn(1'b0, 28'h0000004, 32'h0);
        @(posedge clock); #1;
        read = 1'b1;
        address = 32'h0000_0040;
        @(posedge clock);
        repeat (5) @(posedge clock);
        #2;
        check("pre_reset_mem_read", mem_read, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_mem_read", mem_read, 1'b0);
        check("abort_busywait", busywait, 1'b0);
        check("abort_mem_address", mem_address, 28'h0);
        read = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
`ifdef DCACHE_STATS_EN
        check("rst_hit_count", hit_count, 32'd0);
`endif

        expect_txn(1'b0, 28'h0000004, 32'h0);
        access(1'b0, 32'h0000_0040, 32'h0, 32'h4342_4140, 18, "reread_after_reset");
        check("txq_drained", 128'(txq.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store unit and the 128-bit block data memory.
- Acts as the initiator on the block-memory read/write/busywait protocol. The memory responds after 16 clock beats per block.
- Serves 32-bit word accesses to the CPU with zero wait cycles on a hit.

Parameters:
- NUM_SETS, 8, number of cache lines; power of two, at least 2. INDEX_W = log2(NUM_SETS).
- TAG_W, 28-INDEX_W, tag width (derived, not overridable).

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-high.
- read  in  1  CPU load request.
- write  in  1  CPU store request.
- address  in  32  CPU byte address; [1:0] ignored (word aligned).
- writedata  in  32  CPU store data.
- readdata  out  32  CPU load data.
- busywait  out  1  CPU stall.
- mem_read  out  1  block read request.
- mem_write  out  1  block write request.
- mem_address  out  28  block address (byte address [31:4]).
- mem_writedata  out  128  victim block; byte 0 at [7:0].
- mem_readdata  in  128  fetched block.
- mem_busywait  in  1  memory busy.

Behaviour:
- Address split: tag = address[31:4+INDEX_W]; index = address[4+INDEX_W-1:4]; word = address[3:2]. Word w occupies line bits [32w+31:32w].
- Per-line state: valid, dirty, tag, 128-bit data.
- Reset (async) clears all valid and dirty bits, state goes to IDLE, and every output goes to 0.
- CPU request = read|write. If read and write are both high, the request is handled as a write.
- hit = valid[index] && tag match.
- busywait = request && !(state==IDLE && hit). It is combinational and drops in the same cycle as a hit.
- readdata is combinational: the selected word of line[index] while state==IDLE.
- Write hit: on the posedge, update the word and set dirty. No memory traffic.
- FSM states:
  - IDLE
    - request && miss && dirty → WRITEBACK.
    - request && miss && clean → FETCH.
    - Otherwise stay in IDLE.
  - WRITEBACK
    - mem_write=1; mem_address={victim tag,index}; mem_writedata=line data.
    - Hold all outputs stable.
    - At a posedge with mem_busywait==0 → FETCH.
  - FETCH
    - mem_read=1; mem_address={address tag,index}.
    - At a posedge with mem_busywait==0 → UPDATE.
  - UPDATE
    - mem_read=0, mem_write=0.
    - Write mem_readdata into the line; set valid, clear dirty, load the tag.
    - Unconditionally → IDLE, where the re-lookup hits. A pending write completes on that hit cycle.
- mem_read and mem_write are never high together. Both deassert in the cycle after the completing edge, so the memory's beat counter wraps to 0 for the next access.
- Latency, measured from request to busywait low:
  - hit: 0 cycles.
  - clean miss: 16 (FETCH) + 1 (UPDATE) + 1 = 18 cycles.
  - dirty miss: 34 cycles.
- CPU inputs must stay stable while busywait=1. Changing them mid-miss is not supported.
- Reset mid-WRITEBACK or mid-FETCH aborts the access immediately: requests drop asynchronously and all lines are invalidated.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0].
  - Each counts once per CPU request on the first IDLE cycle of that request. The post-UPDATE re-lookup is not counted as a hit.
  - Counters saturate at 0xFFFFFFFF and are cleared by reset.
- When undefined: no extra ports and no extra logic.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, WRITEBACK, FETCH, UPDATE}.
  - Constants BLOCK_W=128, WORD_W=32, MEM_ADDR_W=28, OFFSET_W=4.
- One natural sub-module, dcache_line_array: valid/dirty/tag/data storage with a combinational read port and a synchronous write port (word write or full-line fill). Its reset clears valid/dirty only.

Test Plan:
- Clean read miss: after reset, read address 0x00000040 with the memory block 0x0000004 holding bytes 0x40..0x4F equal to their addresses. Required:
  - mem_read=1 with mem_address=0x0000004.
  - busywait low 18 cycles after the request.
  - readdata=0x43424140.
- Read hit: next read 0x0000004C → busywait stays 0 and readdata=0x4F4E4D4C in the same cycle.
- Write hit, then dirty eviction:
  - Write 0xDEADBEEF to 0x00000044; dirty[4]=1 and no memory traffic.
  - Then read 0x000000C0 (index 4, tag 1). Required: mem_write at 0x0000004 with mem_writedata[63:32]=0xDEADBEEF, then mem_read at 0x000000C. Total 34 cycles.
- Write miss allocate: write 0x12345678 to 0x00000100 → fetch of block 0x0000010, then word 0 equals 0x12345678 and dirty=1.
- Reset mid-FETCH: assert reset 5 cycles into FETCH.
  - mem_read drops without waiting for a clock edge, and busywait=0.
  - A re-read of 0x00000040 misses again.
- Stats (DCACHE_STATS_EN): the full sequence above yields hit_count=2, miss_count=3.
